// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared types and helpers for the bit-serial datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } deser_state_t;

    // Bits needed to hold a bit count in the range 0..w
    function automatic int count_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sum_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_sum_deserializer_if
// Description : Serial input / parallel valid-ready output bundle of the deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_sum_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_first;
    logic             in_bit;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             frame_error;
    logic             overrun;

    modport master (
        output in_valid, in_first, in_bit, out_ready,
        input  out_valid, out_data, frame_error, overrun
    );

    modport slave (
        input  in_valid, in_first, in_bit, out_ready,
        output out_valid, out_data, frame_error, overrun
    );
endinterface
`default_nettype wire

// File: rtl/out_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : out_hold_reg
// Description : One-entry valid/ready holding register; a load that finds it
//               full and not draining is dropped and flagged with a pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module out_hold_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load_req,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_overrun
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_overrun;
    logic             w_load;
    logic             w_accept;

    // A drain and a load on the same edge hand over without a bubble
    assign w_accept = r_valid & i_ready;
    assign w_load   = i_load_req & (~r_valid | i_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load_req & r_valid & ~i_ready;
            if (w_load) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/serial_sum_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_sum_deserializer
// Description : Collects an LSB-first framed serial bit stream into WIDTH-bit
//               words offered through a one-entry valid/ready holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sum_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    serial_sum_deserializer_if.slave bus
);

    localparam int                 c_CNT_W = count_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    deser_state_t       r_state;
    deser_state_t       w_state_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               r_frame_error;
    logic               w_frame_error_nxt;
    logic               w_shift_en;
    logic               w_complete;
    logic [WIDTH-1:0]   w_shifted;

    // Only the upper WIDTH-1 bits survive a shift, so only those are stored
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_shifted = bus.in_bit;
        end else begin : g_shift_wn
            logic [WIDTH-2:0] r_sr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else if (w_shift_en) begin
                    r_sr <= w_shifted[WIDTH-1:1];
                end
            end

            assign w_shifted = {bus.in_bit, r_sr};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_frame_error <= w_frame_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_frame_error_nxt = 1'b0;
        w_shift_en        = 1'b0;
        w_complete        = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_first) begin
                // A start strobe always begins a fresh word; a partial one is lost
                w_frame_error_nxt = (r_state == COLLECT);
                w_shift_en        = 1'b1;
                if (WIDTH == 1) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_state_nxt = COLLECT;
                    w_count_nxt = c_ONE;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        w_frame_error_nxt = 1'b1;
                    end
                    COLLECT: begin
                        w_shift_en = 1'b1;
                        if (r_count == c_LAST) begin
                            w_complete  = 1'b1;
                            w_state_nxt = IDLE;
                            w_count_nxt = '0;
                        end else begin
                            w_count_nxt = r_count + c_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                        w_count_nxt = '0;
                    end
                endcase
            end
        end
    end

    out_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_load_req(w_complete),
        .i_data    (w_shifted),
        .i_ready   (bus.out_ready),
        .o_valid   (bus.out_valid),
        .o_data    (bus.out_data),
        .o_overrun (bus.overrun)
    );

    assign bus.frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_serial_sum_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sum_deserializer
// Description : Self-checking bench; WIDTH=8 and WIDTH=1 instances share one
//               stimulus stream and are compared against a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sum_deserializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_valid = 1'b0, d_first = 1'b0, d_bit = 1'b0, d_ready = 1'b0;

    always #5 clk = ~clk;

    serial_sum_deserializer_if #(.WIDTH(8)) bus8 ();
    serial_sum_deserializer_if #(.WIDTH(1)) bus1 ();

    assign bus8.in_valid  = d_valid;
    assign bus8.in_first  = d_first;
    assign bus8.in_bit    = d_bit;
    assign bus8.out_ready = d_ready;
    assign bus1.in_valid  = d_valid;
    assign bus1.in_first  = d_first;
    assign bus1.in_bit    = d_bit;
    assign bus1.out_ready = d_ready;

    serial_sum_deserializer #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_sum_deserializer #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_pass = 0;
    int n_checks = 0;

    // Reference model: index 0 is WIDTH=8, index 1 is WIDTH=1
    int         wd [2] = '{8, 1};
    int         m_len [2];
    logic [7:0] m_acc [2];
    logic [7:0] m_data [2];
    logic       m_valid [2];
    logic       m_fe [2];
    logic       m_ov [2];
    logic [7:0] exp8 [$];
    logic [7:0] acc8 [$];

    int          mdl_err = 0;
    int          bad_k = 0;
    logic [10:0] bad_act = '0, bad_exp = '0;
    int          s_fe = 0, s_ov = 0;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_len[k] = 0;  m_acc[k] = '0; m_data[k] = '0;
            m_valid[k] = 1'b0; m_fe[k] = 1'b0; m_ov[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic v, input logic f, input logic b, input logic r);
        logic       done;
        logic [7:0] word;
        for (int k = 0; k < 2; k++) begin
            done = 1'b0; word = '0;
            m_fe[k] = 1'b0; m_ov[k] = 1'b0;
            if (v) begin
                if (f) begin
                    m_fe[k] = (m_len[k] != 0);
                    m_len[k] = 0; m_acc[k] = '0;
                end
                if (f || m_len[k] != 0) begin
                    m_acc[k] = m_acc[k] | (8'(b) << m_len[k]);
                    m_len[k]++;
                end else begin
                    m_fe[k] = 1'b1;
                end
                if (m_len[k] == wd[k]) begin
                    done = 1'b1; word = m_acc[k];
                    m_len[k] = 0; m_acc[k] = '0;
                end
            end
            if (k == 0 && m_valid[0] && r) exp8.push_back(m_data[0]);
            if (done) begin
                if (!m_valid[k] || r) begin
                    m_data[k] = word; m_valid[k] = 1'b1;
                end else begin
                    m_ov[k] = 1'b1;
                end
            end else if (m_valid[k] && r) begin
                m_valid[k] = 1'b0;
            end
        end
    endfunction

    // One clock: drive, advance model, sample 1 time unit after the edge
    task automatic tick(input logic v, input logic f, input logic b, input logic r);
        d_valid = v; d_first = f; d_bit = b; d_ready = r;
        if (bus8.out_valid === 1'b1 && r && !rst) acc8.push_back(bus8.out_data);
        @(posedge clk);
        if (rst) model_reset(); else model_step(v, f, b, r);
        #1;
        if ({bus8.out_valid, bus8.out_data, bus8.frame_error, bus8.overrun} !==
            {m_valid[0], m_data[0], m_fe[0], m_ov[0]}) begin
            mdl_err++; bad_k = 8;
            bad_act = {bus8.out_valid, bus8.out_data, bus8.frame_error, bus8.overrun};
            bad_exp = {m_valid[0], m_data[0], m_fe[0], m_ov[0]};
        end
        if ({bus1.out_valid, bus1.out_data, bus1.frame_error, bus1.overrun} !==
            {m_valid[1], m_data[1][0], m_fe[1], m_ov[1]}) begin
            mdl_err++; bad_k = 1;
            bad_act = {7'd0, bus1.out_valid, bus1.out_data, bus1.frame_error, bus1.overrun};
            bad_exp = {7'd0, m_valid[1], m_data[1][0], m_fe[1], m_ov[1]};
        end
        if (bus8.frame_error === 1'b1) s_fe++;
        if (bus8.overrun === 1'b1) s_ov++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        s_fe = 0; s_ov = 0; mdl_err = 0;
        acc8.delete(); exp8.delete();
    endtask

    task automatic send_word(input logic [7:0] w, input int maxgap, input logic r);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(maxgap, 0)) tick(1'b0, 1'b0, 1'b0, r);
            tick(1'b1, i == 0, w[i], r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus8.out_valid, bus8.out_data, bus8.frame_error, bus8.overrun} !== 11'd0)
            $display("FAIL reset_w8: got %h want 000", {bus8.out_valid, bus8.out_data, bus8.frame_error, bus8.overrun});
        else n_pass++;
        n_checks++;
        if ({bus1.out_valid, bus1.out_data, bus1.frame_error, bus1.overrun} !== 4'd0)
            $display("FAIL reset_w1: got %h want 0", {bus1.out_valid, bus1.out_data, bus1.frame_error, bus1.overrun});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        do_reset();
        send_word(8'hA5, 0, 1'b1);
        n_checks++;
        if ({bus8.out_valid, bus8.out_data} !== {1'b1, 8'hA5})
            $display("FAIL a5_word: got v=%b d=%h want v=1 d=a5", bus8.out_valid, bus8.out_data);
        else n_pass++;
        n_checks++;
        if (s_fe != 0 || s_ov != 0) $display("FAIL a5_pulses: got fe=%0d ov=%0d want 0 0", s_fe, s_ov);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus8.out_valid !== 1'b0) $display("FAIL a5_one_cycle: got v=%b want 0", bus8.out_valid);
        else n_pass++;
        n_checks++;
        if (mdl_err != 0) $display("FAIL a5_model: %0d diffs, w%0d got %h want %h", mdl_err, bad_k, bad_act, bad_exp);
        else n_pass++;
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        logic       early_bad;
        w = 8'h3C; early_bad = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(3, 0)) tick(1'b0, 1'b0, 1'b0, 1'b1);
            if (bus8.out_valid !== 1'b0) early_bad = 1'b1;
            tick(1'b1, i == 0, w[i], 1'b1);
        end
        n_checks++;
        if (early_bad !== 1'b0) $display("FAIL gap_early: got early valid=%b want 0", early_bad);
        else n_pass++;
        n_checks++;
        if ({bus8.out_valid, bus8.out_data} !== {1'b1, 8'h3C})
            $display("FAIL gap_word: got v=%b d=%h want v=1 d=3c", bus8.out_valid, bus8.out_data);
        else n_pass++;
        n_checks++;
        if (mdl_err != 0) $display("FAIL gap_model: %0d diffs, w%0d got %h want %h", mdl_err, bad_k, bad_act, bad_exp);
        else n_pass++;
    endtask

    task automatic test_frame_error();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, i == 0, 1'($urandom), 1'b1);
        send_word(8'hFF, 0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (s_fe != 1) $display("FAIL fe_count: got %0d want 1", s_fe);
        else n_pass++;
        n_checks++;
        if (acc8.size() != 1 || acc8[0] !== 8'hFF)
            $display("FAIL fe_word: got n=%0d d=%h want n=1 d=ff", acc8.size(), (acc8.size() > 0) ? acc8[0] : 8'h00);
        else n_pass++;
    endtask

    task automatic test_overrun();
        do_reset();
        send_word(8'h11, 0, 1'b0);
        send_word(8'h22, 0, 1'b0);
        n_checks++;
        if ({bus8.out_valid, bus8.out_data, bus8.overrun} !== {1'b1, 8'h11, 1'b1})
            $display("FAIL ovr_hold: got v=%b d=%h ov=%b want v=1 d=11 ov=1", bus8.out_valid, bus8.out_data, bus8.overrun);
        else n_pass++;
        n_checks++;
        if (s_ov != 1) $display("FAIL ovr_count: got %0d want 1", s_ov);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus8.out_valid !== 1'b0 || acc8.size() != 1 || acc8[0] !== 8'h11)
            $display("FAIL ovr_drain: got v=%b n=%0d want v=0 n=1 d=11", bus8.out_valid, acc8.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_word(8'h01, 0, 1'b1);
        send_word(8'h80, 0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (acc8.size() != 2 || acc8[0] !== 8'h01 || acc8[1] !== 8'h80)
            $display("FAIL b2b_words: got n=%0d want 01,80", acc8.size());
        else n_pass++;
        n_checks++;
        if (s_ov != 0) $display("FAIL b2b_overrun: got %0d want 0", s_ov);
        else n_pass++;
    endtask

    task automatic test_reset_midword();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, i == 0, 1'b1, 1'b1);
        rst = 1'b1; tick(1'b0, 1'b0, 1'b0, 1'b1); rst = 1'b0;
        send_word(8'h33, 0, 1'b0);
        n_checks++;
        if ({bus8.out_valid, bus8.out_data} !== {1'b1, 8'h33})
            $display("FAIL rst_partial: got v=%b d=%h want v=1 d=33", bus8.out_valid, bus8.out_data);
        else n_pass++;
        rst = 1'b1; tick(1'b0, 1'b0, 1'b0, 1'b0); rst = 1'b0;
        n_checks++;
        if ({bus8.out_valid, bus8.out_data} !== 9'd0)
            $display("FAIL rst_held: got v=%b d=%h want v=0 d=00", bus8.out_valid, bus8.out_data);
        else n_pass++;
        s_fe = 0; acc8.delete();
        send_word(8'h5A, 0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (acc8.size() != 1 || acc8[0] !== 8'h5A || s_fe != 0)
            $display("FAIL rst_next_word: got n=%0d fe=%0d want n=1 d=5a fe=0", acc8.size(), s_fe);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] w;
        int         diffs;
        do_reset();
        repeat (60) begin
            if ($urandom_range(7, 0) == 0) begin
                int len;
                len = $urandom_range(7, 1);
                for (int i = 0; i < len; i++) tick(1'b1, i == 0, 1'($urandom), $urandom_range(3, 0) != 0);
            end
            if ($urandom_range(9, 0) == 0) tick(1'b1, 1'b0, 1'($urandom), 1'b1);
            w = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(3, 0)) tick(1'b0, 1'b0, 1'b0, $urandom_range(3, 0) != 0);
                tick(1'b1, i == 0, w[i], $urandom_range(3, 0) != 0);
            end
        end
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (mdl_err != 0) $display("FAIL rand_model: %0d diffs, w%0d got %h want %h", mdl_err, bad_k, bad_act, bad_exp);
        else n_pass++;
        diffs = 0;
        for (int i = 0; i < acc8.size() && i < exp8.size(); i++) if (acc8[i] !== exp8[i]) diffs++;
        n_checks++;
        if (acc8.size() != exp8.size() || diffs != 0)
            $display("FAIL rand_stream: got n=%0d diffs=%0d want n=%0d diffs=0", acc8.size(), diffs, exp8.size());
        else n_pass++;
    endtask

    task automatic test_width1();
        do_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({bus1.out_valid, bus1.out_data} !== 2'b11)
            $display("FAIL w1_word: got v=%b d=%b want v=1 d=1", bus1.out_valid, bus1.out_data);
        else n_pass++;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus1.frame_error, bus1.out_valid} !== 2'b10)
            $display("FAIL w1_frame: got fe=%b v=%b want fe=1 v=0", bus1.frame_error, bus1.out_valid);
        else n_pass++;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({bus1.out_valid, bus1.out_data, bus1.overrun} !== 3'b101)
            $display("FAIL w1_overrun: got v=%b d=%b ov=%b want v=1 d=0 ov=1", bus1.out_valid, bus1.out_data, bus1.overrun);
        else n_pass++;
        n_checks++;
        if (mdl_err != 0) $display("FAIL w1_model: %0d diffs, w%0d got %h want %h", mdl_err, bad_k, bad_act, bad_exp);
        else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_midword();
        test_random();
        test_width1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
